// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter that shares the VGA pixel write port between sprite drawers using locked bursts.
// Optional macro PIXEL_ARB_PRIO0_EN gives requester 0 fixed top priority whenever the arbiter is idle.
module pixel_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_last,
    input  logic [8*NUM_REQ-1:0] i_x_in,
    input  logic [7*NUM_REQ-1:0] i_y_in,
    input  logic [3*NUM_REQ-1:0] i_color_in,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [7:0]           o_x_out,
    output logic [6:0]           o_y_out,
    output logic [2:0]           o_color_out,
    output logic                 o_writeEn,
    output logic                 o_busy,
    output logic [IDW-1:0]       o_owner
);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_pick;
    logic [7:0]     r_count;
    logic [7:0]     r_x;
    logic [6:0]     r_y;
    logic [2:0]     r_color;
    logic           r_writeEn;
    logic           w_found;
    logic           w_xfer;
    logic           w_release;

    function automatic logic [IDW-1:0] wrapIdx(input logic [IDW-1:0] base, input int step);
        wrapIdx = IDW'((int'(base) + step) % NUM_REQ);
    endfunction

    // Search starts just after the last owner, so the most recently served requester is checked last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && i_req[wrapIdx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrapIdx(r_ptr, k);
            end
        end
`ifdef PIXEL_ARB_PRIO0_EN
        if (i_req[0]) begin
            w_found = 1'b1;
            w_pick  = '0;
        end
`endif
    end

    always_comb begin
        w_nextState = r_state;
        o_gnt       = '0;
        w_xfer      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_nextState = S_LOCK;
            end
            S_LOCK: begin
                o_gnt[r_owner] = 1'b1;
                w_xfer         = i_req[r_owner];
                // Dropped req abandons the burst; otherwise last pixel or burst cap ends it.
                w_release      = !i_req[r_owner] || i_last[r_owner] ||
                                 (r_count == 8'(MAX_BURST - 1));
                if (w_release) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner   <= '0;
            r_ptr     <= IDW'(NUM_REQ - 1);
            r_count   <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_color   <= '0;
            r_writeEn <= 1'b0;
        end else begin
            r_writeEn <= w_xfer;
            if (w_xfer) begin
                r_x     <= i_x_in[8*r_owner +: 8];
                r_y     <= i_y_in[7*r_owner +: 7];
                r_color <= i_color_in[3*r_owner +: 3];
                r_count <= r_count + 8'd1;
            end
            if (r_state == S_IDLE && w_found) begin
                r_owner <= w_pick;
                r_count <= '0;
            end
`ifdef PIXEL_ARB_PRIO0_EN
            // The player never advances the pointer, so the others keep their rotation order.
            if (w_release && r_owner != '0) r_ptr <= r_owner;
`else
            if (w_release) r_ptr <= r_owner;
`endif
        end
    end

    assign o_x_out     = r_x;
    assign o_y_out     = r_y;
    assign o_color_out = r_color;
    assign o_writeEn   = r_writeEn;
    assign o_busy      = (r_state == S_LOCK);
    assign o_owner     = r_owner;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomized and directed bench for pixel_write_arbiter, checked every cycle against a behavioural model.
// Honours PIXEL_ARB_PRIO0_EN in the model and in the priority scenario expectations.
module tb_pixel_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 16;
    localparam int IDW       = $clog2(NUM_REQ);

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ-1:0]   last = '0;
    logic [8*NUM_REQ-1:0] xIn = '0;
    logic [7*NUM_REQ-1:0] yIn = '0;
    logic [3*NUM_REQ-1:0] colorIn = '0;
    logic [NUM_REQ-1:0]   gnt;
    logic [7:0]           xOut;
    logic [6:0]           yOut;
    logic [2:0]           colorOut;
    logic                 writeEn;
    logic                 busy;
    logic [IDW-1:0]       owner;

    int vectors = 0;
    int miscompares = 0;

    pixel_write_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .i_clk(clock), .i_reset(reset), .i_req(req), .i_last(last),
        .i_x_in(xIn), .i_y_in(yIn), .i_color_in(colorIn),
        .o_gnt(gnt), .o_x_out(xOut), .o_y_out(yOut), .o_color_out(colorOut),
        .o_writeEn(writeEn), .o_busy(busy), .o_owner(owner)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the port, where the rotation resumes, and what was last plotted.
    bit         modelValid = 1'b0;
    bit         mLocked;
    int         mOwner, mPtr, mCount, mPick;
    logic [7:0] mX;
    logic [6:0] mY;
    logic [2:0] mC;
    bit         mWe;

    always @(posedge clock) begin
        if (reset) begin
            modelValid = 1'b1;
            mLocked = 1'b0; mOwner = 0; mPtr = NUM_REQ - 1; mCount = 0;
            mX = '0; mY = '0; mC = '0; mWe = 1'b0;
        end else if (modelValid) begin
            if (!mLocked) begin
                mWe = 1'b0;
                if (req != '0) begin
                    mPick = -1;
`ifdef PIXEL_ARB_PRIO0_EN
                    if (req[0]) mPick = 0;
`endif
                    for (int k = 1; k <= NUM_REQ; k++)
                        if (mPick < 0 && req[(mPtr + k) % NUM_REQ]) mPick = (mPtr + k) % NUM_REQ;
                    mOwner = mPick; mLocked = 1'b1; mCount = 0;
                end
            end else begin
                mWe = req[mOwner];
                if (mWe) begin
                    mX = xIn[8*mOwner +: 8];
                    mY = yIn[7*mOwner +: 7];
                    mC = colorIn[3*mOwner +: 3];
                    mCount++;
                end
                if (!mWe || last[mOwner] || mCount == MAX_BURST) begin
                    mLocked = 1'b0;
`ifdef PIXEL_ARB_PRIO0_EN
                    if (mOwner != 0) mPtr = mOwner;
`else
                    mPtr = mOwner;
`endif
                end
            end
        end
    end

    int  grantLog[$];
    int  burstWrites[$];
    int  lastX = -1;
    bit  prevBusy = 1'b0;

    always @(negedge clock) begin
        if (modelValid) begin
            checkOutput("gnt", 32'(gnt), mLocked ? (32'd1 << mOwner) : 32'd0);
            checkOutput("busy", 32'(busy), 32'(mLocked));
            checkOutput("owner", 32'(owner), 32'(mOwner));
            checkOutput("writeEn", 32'(writeEn), 32'(mWe));
            checkOutput("x_out", 32'(xOut), 32'(mX));
            checkOutput("y_out", 32'(yOut), 32'(mY));
            checkOutput("color_out", 32'(colorOut), 32'(mC));
        end
        if (writeEn === 1'b1) begin
            lastX = int'(xOut);
            if (burstWrites.size() > 0) burstWrites[burstWrites.size()-1]++;
        end
        if (busy === 1'b1 && !prevBusy) begin
            grantLog.push_back(int'(owner));
            burstWrites.push_back(0);
        end
        prevBusy = (busy === 1'b1);
    end

    // Per-requester pixel streams: a sprite holds its pixel until accepted, then moves on.
    bit         active[NUM_REQ], cont[NUM_REQ], accPend[NUM_REQ];
    int         pIdx[NUM_REQ], bLen[NUM_REQ], dropAt[NUM_REQ];
    logic [7:0] baseX[NUM_REQ];
    logic [6:0] baseY[NUM_REQ];
    logic [2:0] baseC[NUM_REQ];
    bit         randMode = 1'b0;

    task automatic applyStimulus(input bit rst);
        @(negedge clock);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accPend[i]) begin
                if (pIdx[i] == bLen[i] - 1) begin
                    pIdx[i] = 0;
                    if (!cont[i]) active[i] = 1'b0;
                end else begin
                    pIdx[i]++;
                end
                if (dropAt[i] != 0 && pIdx[i] == dropAt[i]) active[i] = 1'b0;
            end
            if (randMode && !active[i] && $urandom_range(0, 3) == 0) begin
                active[i] = 1'b1; cont[i] = 1'b0; pIdx[i] = 0;
                bLen[i]   = int'($urandom_range(1, 20));
                dropAt[i] = (bLen[i] > 1 && $urandom_range(0, 4) == 0) ?
                            int'($urandom_range(1, bLen[i] - 1)) : 0;
                baseX[i] = 8'($urandom); baseY[i] = 7'($urandom); baseC[i] = 3'($urandom);
            end
        end
        reset = rst;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]             = active[i];
            xIn[8*i +: 8]      = baseX[i] + 8'(pIdx[i]);
            yIn[7*i +: 7]      = baseY[i];
            colorIn[3*i +: 3]  = baseC[i];
            last[i]            = active[i] ? (pIdx[i] == bLen[i] - 1) : ($urandom_range(0, 1) == 1);
            accPend[i]         = req[i] && (gnt[i] === 1'b1) && !rst;
        end
    endtask

    task automatic clearStreams();
        for (int i = 0; i < NUM_REQ; i++) begin
            active[i] = 1'b0; cont[i] = 1'b0; accPend[i] = 1'b0;
            pIdx[i] = 0; bLen[i] = 1; dropAt[i] = 0;
            baseX[i] = '0; baseY[i] = '0; baseC[i] = '0;
        end
    endtask

    task automatic startStream(input int i, input int len, input bit isCont, input int drop,
                               input logic [7:0] bx, input logic [6:0] by, input logic [2:0] bc);
        active[i] = 1'b1; cont[i] = isCont; pIdx[i] = 0; bLen[i] = len; dropAt[i] = drop;
        baseX[i] = bx; baseY[i] = by; baseC[i] = bc;
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    task automatic resetDut();
        clearStreams();
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        grantLog.delete();
        burstWrites.delete();
    endtask

    function automatic int logAt(input int q[$], input int i);
        logAt = (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        clearStreams();

        // Single 12-pixel burst from requester 1.
        resetDut();
        startStream(1, 12, 1'b0, 0, 8'd10, 7'd5, 3'b110);
        runCycles(20);
        checkOutput("single_grants", 32'(grantLog.size()), 32'd1);
        checkOutput("single_owner", 32'(logAt(grantLog, 0)), 32'd1);
        checkOutput("single_writes", 32'(logAt(burstWrites, 0)), 32'd12);
        checkOutput("single_lastx", 32'(lastX), 32'd21);
        checkOutput("single_idle", 32'(busy), 32'd0);

        // Round robin between requesters 0 and 2 with 4-pixel bursts.
        resetDut();
        startStream(0, 4, 1'b1, 0, 8'd30, 7'd1, 3'd1);
        startStream(2, 4, 1'b1, 0, 8'd60, 7'd2, 3'd2);
        runCycles(22);
        checkOutput("rr_owner0", 32'(logAt(grantLog, 0)), 32'd0);
        checkOutput("rr_owner1", 32'(logAt(grantLog, 1)), 32'd2);
        checkOutput("rr_owner2", 32'(logAt(grantLog, 2)), 32'd0);
        checkOutput("rr_owner3", 32'(logAt(grantLog, 3)), 32'd2);
        checkOutput("rr_writes", 32'(logAt(burstWrites, 1)), 32'd4);

        // Forced release after MAX_BURST pixels, then the waiting requester 0 wins.
        resetDut();
        startStream(3, 1000, 1'b1, 0, 8'd100, 7'd20, 3'd2);
        runCycles(2);
        startStream(0, 2, 1'b0, 0, 8'd200, 7'd30, 3'd1);
        runCycles(24);
        checkOutput("forced_owner", 32'(logAt(grantLog, 0)), 32'd3);
        checkOutput("forced_writes", 32'(logAt(burstWrites, 0)), 32'd16);
        checkOutput("forced_next", 32'(logAt(grantLog, 1)), 32'd0);
        checkOutput("forced_next_writes", 32'(logAt(burstWrites, 1)), 32'd2);

        // Abandoned burst after 3 pixels.
        resetDut();
        startStream(2, 10, 1'b0, 3, 8'd50, 7'd40, 3'd5);
        runCycles(8);
        checkOutput("abandon_grants", 32'(grantLog.size()), 32'd1);
        checkOutput("abandon_writes", 32'(logAt(burstWrites, 0)), 32'd3);

        // Reset in the middle of a burst drops the in-flight pixel.
        startStream(1, 30, 1'b0, 0, 8'd90, 7'd11, 3'd7);
        runCycles(5);
        applyStimulus(1'b1);
        @(posedge clock);
        #1;
        checkOutput("rst_writeEn", 32'(writeEn), 32'd0);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_x", 32'(xOut), 32'd0);
        clearStreams();
        grantLog.delete();
        burstWrites.delete();
        startStream(3, 2, 1'b0, 0, 8'd5, 7'd6, 3'd3);
        startStream(0, 2, 1'b0, 0, 8'd7, 7'd8, 3'd4);
        runCycles(10);
        checkOutput("rst_ptr_first", 32'(logAt(grantLog, 0)), 32'd0);
        checkOutput("rst_ptr_second", 32'(logAt(grantLog, 1)), 32'd3);

        // One-pixel burst: last on the very first pixel.
        resetDut();
        startStream(1, 1, 1'b0, 0, 8'd77, 7'd9, 3'd4);
        runCycles(6);
        checkOutput("onepix_writes", 32'(logAt(burstWrites, 0)), 32'd1);
        checkOutput("onepix_lastx", 32'(lastX), 32'd77);
        checkOutput("onepix_idle", 32'(busy), 32'd0);

        // Requesters 0 and 1 both keep requesting 2-pixel bursts.
        resetDut();
        startStream(0, 2, 1'b1, 0, 8'd140, 7'd3, 3'd1);
        startStream(1, 2, 1'b1, 0, 8'd150, 7'd4, 3'd2);
        runCycles(14);
        checkOutput("prio_owner0", 32'(logAt(grantLog, 0)), 32'd0);
`ifdef PIXEL_ARB_PRIO0_EN
        checkOutput("prio_owner1", 32'(logAt(grantLog, 1)), 32'd0);
        checkOutput("prio_owner2", 32'(logAt(grantLog, 2)), 32'd0);
        checkOutput("prio_owner3", 32'(logAt(grantLog, 3)), 32'd0);
`else
        checkOutput("prio_owner1", 32'(logAt(grantLog, 1)), 32'd1);
        checkOutput("prio_owner2", 32'(logAt(grantLog, 2)), 32'd0);
        checkOutput("prio_owner3", 32'(logAt(grantLog, 3)), 32'd1);
`endif

        // Random traffic with occasional resets.
        resetDut();
        randMode = 1'b1;
        repeat (800) applyStimulus($urandom_range(0, 99) == 0);
        randMode = 1'b0;
        clearStreams();
        runCycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
